fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and load-use hazard unit for the in-order pipeline.
- Compares decode-stage source registers against the destinations in the EX and MEM stages.
- Drives per-operand forward selects and forwarded data.
- Stalls decode for a programmable number of cycles on a load-use hazard, and keeps a saturating hazard-stall counter.

Parameters:
- REG_ADDR_W, 3, register index width.
- DATA_W, 10, datapath width.
- NUM_SRC, 2, number of decode source operands.
- LOAD_LAT, 1, decode stall cycles per load-use hazard (>=1).
- ZERO_REG_EN, 1, 1 = register 0 is hardwired and never matched.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode holds a real instruction.
- id_src_regs  in  NUM_SRC*REG_ADDR_W  source register indices; operand i occupies slice [i*REG_ADDR_W +: REG_ADDR_W].
- id_src_used  in  NUM_SRC  operand i is actually read.
- flush  in  1  pipeline flush (branch redirect).
- ex_wr  in  1  EX instruction writes a register.
- ex_is_load  in  1  EX instruction is a load; its data is not yet available.
- ex_dest_reg  in  REG_ADDR_W  EX destination register.
- ex_result  in  DATA_W  EX ALU result.
- mem_wr  in  1  MEM instruction writes a register.
- mem_dest_reg  in  REG_ADDR_W  MEM destination register.
- mem_result  in  DATA_W  MEM write-back value, including load data.
- fwd_sel  out  2*NUM_SRC  per operand: 00 regfile, 01 EX, 10 MEM, 11 unused.
- fwd_data  out  NUM_SRC*DATA_W  forwarded value per operand; 0 when fwd_sel=00.
- stall  out  1  hold PC and the IF/ID register.
- bubble  out  1  insert a NOP into EX; always equals stall.
- stall_cnt  out  CNT_W  total stalled cycles, saturating.

Behaviour:
- Match rule for operand i and a stage S:
  - match when id_valid, id_src_used[i], S_wr, and src==S_dest all hold;
  - with ZERO_REG_EN=1, src==0 never matches.
- Forward priority:
  - EX match with ex_is_load=0 -> sel 01, data ex_result;
  - else MEM match -> sel 10, data mem_result;
  - else sel 00, data 0.
  - EX has priority over MEM: it holds the newer value.
- Forward path: fwd_sel and fwd_data are combinational, with zero latency.
- FSM states: IDLE, STALL. Registers: state, cnt (ceil(log2(LOAD_LAT+1)) bits), pend_reg, stall_cnt.
- Load-use hazard: in IDLE, any operand with an EX match while ex_is_load=1.
- IDLE:
  - on a hazard (and flush=0): stall=1 this cycle combinationally, and fwd_sel for the hazard operand = 00.
  - at the next edge: if LOAD_LAT>1 go to STALL with cnt=LOAD_LAT-1 and pend_reg=ex_dest_reg; if LOAD_LAT==1 stay in IDLE.
- STALL:
  - stall=1 and bubble=1; fwd_sel for operands matching pend_reg = 00.
  - each edge decrements cnt; at cnt==1 the next state is IDLE.
  - the load has then reached MEM, so IDLE forwarding selects MEM with no extra stall.
- flush=1 in either state: stall=0 and bubble=0 that cycle, next state IDLE, cnt=0. flush has priority over hazard detection.
- id_valid=0: no match, no hazard, fwd_sel all 00. An in-progress STALL still completes unless flushed.
- stall_cnt: increments on every edge where stall=1; holds at all-ones.
- Simultaneous events:
  - two operands hazarding on the same load cause a single stall sequence;
  - one operand on EX (non-load) and the other on MEM forward independently in the same cycle.
- Reset (asserted at any time, including mid-stall): immediately state=IDLE, cnt=0, pend_reg=0, stall_cnt=0.
  - while rst_n=0, stall, bubble, fwd_sel and fwd_data are forced to 0 regardless of inputs.
  - normal operation resumes on the first clk edge after release.

Test Plan:
- Reset mid-STALL (LOAD_LAT=3):
  - drop rst_n during the 2nd stall cycle -> stall=0, fwd_sel=0 and stall_cnt=0 immediately (async);
  - after release, a quiet pipeline gives stall=0.
- EX/MEM priority:
  - src0=3, src1=5, ex_wr=1, ex_dest=3, ex_result=0x155, mem_wr=1, mem_dest=3, mem_result=0x0AA;
  - expect fwd_sel[1:0]=01, fwd_data0=0x155, fwd_sel[3:2]=00, stall=0.
- Zero register: src0=0, ex_dest=0, ex_wr=1 with ZERO_REG_EN=1 -> fwd_sel=00. With ZERO_REG_EN=0 -> fwd_sel=01.
- Load-use, LOAD_LAT=1:
  - ex_is_load=1, ex_dest=2, src1=2 -> stall=bubble=1 for exactly 1 cycle;
  - next cycle with mem_dest=2, mem_result=0x3FF: fwd_sel[3:2]=10, data 0x3FF, stall=0; stall_cnt=1.
- Load-use, LOAD_LAT=3: same stimulus -> stall high for 3 consecutive cycles, then MEM forward; stall_cnt=3.
- Flush and saturation:
  - flush=1 in the 1st STALL cycle -> stall=0 that cycle and the FSM returns to IDLE;
  - with CNT_W=4, a continuous 20-cycle stall leaves stall_cnt=15.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for the in-order pipeline.
// Matches decode source operands against the EX/MEM destinations, selects
// forwarded data per operand, stalls decode on load-use hazards for LOAD_LAT
// cycles and keeps a saturating count of stalled cycles.
module fwd_hazard_unit #(
  parameter int unsigned REG_ADDR_W  = 3,
  parameter int unsigned DATA_W      = 10,
  parameter int unsigned NUM_SRC     = 2,
  parameter int unsigned LOAD_LAT    = 1,
  parameter int unsigned ZERO_REG_EN = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_regs,
  input  logic [NUM_SRC-1:0]            id_src_used,
  input  logic                          flush,
  input  logic                          ex_wr,
  input  logic                          ex_is_load,
  input  logic [REG_ADDR_W-1:0]         ex_dest_reg,
  input  logic [DATA_W-1:0]             ex_result,
  input  logic                          mem_wr,
  input  logic [REG_ADDR_W-1:0]         mem_dest_reg,
  input  logic [DATA_W-1:0]             mem_result,
  output logic [2*NUM_SRC-1:0]          fwd_sel,
  output logic [NUM_SRC*DATA_W-1:0]     fwd_data,
  output logic                          stall,
  output logic                          bubble,
  output logic [CNT_W-1:0]              stall_cnt
);

  localparam int unsigned CW = $clog2(LOAD_LAT + 1);

  typedef enum logic {IDLE, STALL} state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic [REG_ADDR_W-1:0]   pend_reg, pend_nxt;
  logic [NUM_SRC-1:0]      live, match_ex, match_mem, match_pend, hz_op, hold_mask;
  logic                    stall_int;

  // Per-operand match against EX, MEM and the pending load destination
  always_comb begin
    live       = '0;
    match_ex   = '0;
    match_mem  = '0;
    match_pend = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      live[i] = id_valid && id_src_used[i] &&
                !((ZERO_REG_EN != 0) && (id_src_regs[i*REG_ADDR_W +: REG_ADDR_W] == '0));
      match_ex[i]   = live[i] && ex_wr  && (id_src_regs[i*REG_ADDR_W +: REG_ADDR_W] == ex_dest_reg);
      match_mem[i]  = live[i] && mem_wr && (id_src_regs[i*REG_ADDR_W +: REG_ADDR_W] == mem_dest_reg);
      match_pend[i] = live[i] && (id_src_regs[i*REG_ADDR_W +: REG_ADDR_W] == pend_reg);
    end
    hz_op = match_ex & {NUM_SRC{ex_is_load}};
  end

  // Stall FSM next-state logic; flush overrides any hazard or pending stall
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pend_nxt  = pend_reg;
    stall_int = 1'b0;
    hold_mask = '0;
    unique case (state)
      IDLE: begin
        if (|hz_op) begin
          stall_int = 1'b1;
          hold_mask = hz_op;
          if (LOAD_LAT > 1) begin
            state_nxt = STALL;
            cnt_nxt   = CW'(LOAD_LAT - 1);
            pend_nxt  = ex_dest_reg;
          end
        end
      end
      STALL: begin
        stall_int = 1'b1;
        hold_mask = match_pend;
        cnt_nxt   = cnt - 1'b1;
        if (cnt == CW'(1)) state_nxt = IDLE;
      end
    endcase
    if (flush) begin
      stall_int = 1'b0;
      hold_mask = '0;
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end
  end

  // Forward select and data, forced to zero while reset is asserted
  always_comb begin
    fwd_sel  = '0;
    fwd_data = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (rst_n && !hold_mask[i]) begin
        if (match_ex[i] && !ex_is_load) begin
          fwd_sel[2*i +: 2]           = 2'b01;
          fwd_data[i*DATA_W +: DATA_W] = ex_result;
        end else if (match_mem[i]) begin
          fwd_sel[2*i +: 2]           = 2'b10;
          fwd_data[i*DATA_W +: DATA_W] = mem_result;
        end
      end
    end
  end

  assign stall  = stall_int && rst_n;
  assign bubble = stall;

  // FSM state, stall countdown and pending load destination
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      pend_reg <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      pend_reg <= pend_nxt;
    end
  end

  // Saturating count of stalled cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall_int && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: two instances with different
// parameters share stimulus, each held in reset while the other is exercised.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic        id_valid, flush, ex_wr, ex_is_load, mem_wr;
  logic [5:0]  id_src_regs;
  logic [1:0]  id_src_used;
  logic [2:0]  ex_dest_reg, mem_dest_reg;
  logic [9:0]  ex_result, mem_result;

  logic [3:0]  sel_a, sel_b;
  logic [19:0] data_a, data_b;
  logic        stall_a, stall_b, bub_a, bub_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  typedef struct {
    int         cyc;
    string      name;
    bit         dut;
    logic [3:0] sel;
    logic [19:0] data;
    logic       st;
    bit         chk_cnt;
    int         cnt;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.REG_ADDR_W(3), .DATA_W(10), .NUM_SRC(2), .LOAD_LAT(3),
                    .ZERO_REG_EN(1), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_a), .id_valid(id_valid), .id_src_regs(id_src_regs),
    .id_src_used(id_src_used), .flush(flush), .ex_wr(ex_wr), .ex_is_load(ex_is_load),
    .ex_dest_reg(ex_dest_reg), .ex_result(ex_result), .mem_wr(mem_wr),
    .mem_dest_reg(mem_dest_reg), .mem_result(mem_result), .fwd_sel(sel_a),
    .fwd_data(data_a), .stall(stall_a), .bubble(bub_a), .stall_cnt(cnt_a));

  fwd_hazard_unit #(.REG_ADDR_W(3), .DATA_W(10), .NUM_SRC(2), .LOAD_LAT(1),
                    .ZERO_REG_EN(0), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_b), .id_valid(id_valid), .id_src_regs(id_src_regs),
    .id_src_used(id_src_used), .flush(flush), .ex_wr(ex_wr), .ex_is_load(ex_is_load),
    .ex_dest_reg(ex_dest_reg), .ex_result(ex_result), .mem_wr(mem_wr),
    .mem_dest_reg(mem_dest_reg), .mem_result(mem_result), .fwd_sel(sel_b),
    .fwd_data(data_b), .stall(stall_b), .bubble(bub_b), .stall_cnt(cnt_b));

  // Cycle index shared by stimulus and monitor
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pop expectations due this cycle and compare mid-cycle
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t        e;
      logic [3:0]  s;
      logic [19:0] d;
      logic        st, bb;
      int          c;
      bit          bad;
      e  = sb.pop_front();
      s  = e.dut ? sel_b   : sel_a;
      d  = e.dut ? data_b  : data_a;
      st = e.dut ? stall_b : stall_a;
      bb = e.dut ? bub_b   : bub_a;
      c  = e.dut ? int'(cnt_b) : int'(cnt_a);
      checks++;
      bad = (e.cyc != cyc) || (s !== e.sel) || (d !== e.data) || (st !== e.st) ||
            (bb !== e.st) || (e.chk_cnt && (c != e.cnt));
      if (bad) begin
        errors++;
        $display("FAIL %s: got sel=%b data=%h stall=%b bubble=%b cnt=%0d, want sel=%b data=%h stall=%b bubble=%b cnt=%0d",
                 e.name, s, d, st, bb, c, e.sel, e.data, e.st, e.st, e.cnt);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] u, input int s0, input int s1,
                       input logic ew, input logic el, input int ed, input logic [9:0] er,
                       input logic mw, input int md, input logic [9:0] mr, input logic fl);
    id_valid     = v;
    id_src_used  = u;
    id_src_regs  = {3'(s1), 3'(s0)};
    ex_wr        = ew;
    ex_is_load   = el;
    ex_dest_reg  = 3'(ed);
    ex_result    = er;
    mem_wr       = mw;
    mem_dest_reg = 3'(md);
    mem_result   = mr;
    flush        = fl;
  endtask

  task automatic expect_out(input string name, input bit dut, input logic [3:0] sel,
                            input logic [19:0] data, input logic st,
                            input bit chk_cnt, input int cnt);
    exp_t e;
    e.cyc = cyc; e.name = name; e.dut = dut; e.sel = sel; e.data = data;
    e.st = st; e.chk_cnt = chk_cnt; e.cnt = cnt;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    drive(1, 2'b11, 3, 0, 1, 0, 3, 10'h155, 0, 0, 10'h000, 0);
    step();
    // Reset forces outputs low even with an EX match present
    expect_out("a_reset", 0, 4'b0000, 20'h0, 1'b0, 1, 0);
    step();
    rst_a = 1'b1;
    drive(0, 2'b00, 0, 0, 0, 0, 0, 10'h000, 0, 0, 10'h000, 0);
    step();

    // Forwarding priority and operand independence
    drive(1, 2'b11, 3, 5, 1, 0, 3, 10'h155, 1, 3, 10'h0AA, 0);
    expect_out("a_prio", 0, 4'b0001, {10'h000, 10'h155}, 1'b0, 1, 0);
    step();
    drive(1, 2'b11, 3, 5, 1, 0, 3, 10'h155, 1, 5, 10'h0AA, 0);
    expect_out("a_ex_mem_split", 0, 4'b1001, {10'h0AA, 10'h155}, 1'b0, 0, 0);
    step();
    drive(1, 2'b01, 3, 5, 1, 0, 3, 10'h155, 1, 5, 10'h0AA, 0);
    expect_out("a_unused_src", 0, 4'b0001, {10'h000, 10'h155}, 1'b0, 0, 0);
    step();
    drive(1, 2'b11, 3, 3, 1, 0, 3, 10'h155, 1, 3, 10'h0AA, 0);
    expect_out("a_both_ex", 0, 4'b0101, {10'h155, 10'h155}, 1'b0, 0, 0);
    step();
    drive(1, 2'b11, 0, 0, 1, 0, 0, 10'h155, 1, 0, 10'h0AA, 0);
    expect_out("a_zero_reg", 0, 4'b0000, 20'h0, 1'b0, 0, 0);
    step();
    drive(0, 2'b11, 3, 5, 1, 0, 3, 10'h155, 1, 5, 10'h0AA, 0);
    expect_out("a_no_valid", 0, 4'b0000, 20'h0, 1'b0, 0, 0);
    step();

    // Load-use with three stall cycles, then MEM forward
    drive(1, 2'b11, 1, 2, 1, 1, 2, 10'h123, 0, 0, 10'h000, 0);
    expect_out("a_ld_c0", 0, 4'b0000, 20'h0, 1'b1, 1, 0);
    step();
    drive(1, 2'b11, 1, 2, 0, 0, 0, 10'h000, 0, 0, 10'h000, 0);
    expect_out("a_ld_c1", 0, 4'b0000, 20'h0, 1'b1, 1, 1);
    step();
    drive(1, 2'b11, 1, 2, 0, 0, 0, 10'h000, 1, 2, 10'h2AA, 0);
    expect_out("a_ld_c2_pend", 0, 4'b0000, 20'h0, 1'b1, 1, 2);
    step();
    drive(1, 2'b11, 1, 2, 0, 0, 0, 10'h000, 1, 2, 10'h3FF, 0);
    expect_out("a_ld_mem_fwd", 0, 4'b1000, {10'h3FF, 10'h000}, 1'b0, 1, 3);
    step();

    // Flush in the first STALL cycle returns to IDLE
    drive(1, 2'b11, 1, 2, 1, 1, 2, 10'h123, 0, 0, 10'h000, 0);
    expect_out("a_fl_c0", 0, 4'b0000, 20'h0, 1'b1, 1, 3);
    step();
    drive(1, 2'b11, 1, 2, 0, 0, 0, 10'h000, 0, 0, 10'h000, 1);
    expect_out("a_fl_c1", 0, 4'b0000, 20'h0, 1'b0, 1, 4);
    step();
    drive(1, 2'b11, 1, 2, 0, 0, 0, 10'h000, 0, 0, 10'h000, 0);
    expect_out("a_fl_idle", 0, 4'b0000, 20'h0, 1'b0, 1, 4);
    step();

    // Asynchronous reset during the second stall cycle
    drive(1, 2'b11, 1, 2, 1, 1, 2, 10'h123, 0, 0, 10'h000, 0);
    expect_out("a_rs_c0", 0, 4'b0000, 20'h0, 1'b1, 1, 4);
    step();
    drive(1, 2'b11, 1, 2, 0, 0, 0, 10'h000, 1, 1, 10'h111, 0);
    rst_a = 1'b0;
    expect_out("a_rs_async", 0, 4'b0000, 20'h0, 1'b0, 1, 0);
    step();
    rst_a = 1'b1;
    drive(1, 2'b11, 1, 2, 0, 0, 0, 10'h000, 0, 0, 10'h000, 0);
    expect_out("a_rs_quiet0", 0, 4'b0000, 20'h0, 1'b0, 1, 0);
    step();
    expect_out("a_rs_quiet1", 0, 4'b0000, 20'h0, 1'b0, 1, 0);
    step();

    // Second instance: LOAD_LAT=1, register 0 not hardwired, 4-bit counter
    rst_a = 1'b0;
    rst_b = 1'b1;
    drive(0, 2'b00, 0, 0, 0, 0, 0, 10'h000, 0, 0, 10'h000, 0);
    step();
    drive(1, 2'b01, 0, 0, 1, 0, 0, 10'h0F0, 0, 0, 10'h000, 0);
    expect_out("b_zero_reg", 1, 4'b0001, {10'h000, 10'h0F0}, 1'b0, 1, 0);
    step();
    drive(1, 2'b11, 1, 2, 1, 1, 2, 10'h123, 0, 0, 10'h000, 0);
    expect_out("b_ld", 1, 4'b0000, 20'h0, 1'b1, 1, 0);
    step();
    drive(1, 2'b11, 1, 2, 0, 0, 0, 10'h000, 1, 2, 10'h3FF, 0);
    expect_out("b_ld_mem_fwd", 1, 4'b1000, {10'h3FF, 10'h000}, 1'b0, 1, 1);
    step();
    for (int k = 0; k < 20; k++) begin
      drive(1, 2'b11, 1, 2, 1, 1, 2, 10'h123, 0, 0, 10'h000, 0);
      expect_out("b_sat", 1, 4'b0000, 20'h0, 1'b1, 1, (k + 1 > 15) ? 15 : k + 1);
      step();
    end
    drive(1, 2'b11, 1, 2, 0, 0, 0, 10'h000, 0, 0, 10'h000, 0);
    expect_out("b_sat_end", 1, 4'b0000, 20'h0, 1'b0, 1, 15);
    step();

    repeat (2) step();
    if (sb.size() != 0) begin
      errors += sb.size();
      checks += sb.size();
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
